// File: rtl/cmd_table_pkg.sv
// Shared types and helpers for the command-table streamer.
package cmd_table_pkg;

  localparam logic [7:0] TERM_WORD_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  // Width needed to hold a word count in 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/cmd_table_rom.sv
// Single-port synchronous ROM, one cycle read latency; vendor macro in the FPGA flow,
// plain array model elsewhere (contents loaded by the environment).
module cmd_table_rom #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter     INIT_FILE = "./cmd_parser_cmd_table.mif"
) (
  input  logic              clock,
  input  logic              rden,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q
);

`ifdef ALTERA_RESERVED_QIS
  altsyncram #(
    .operation_mode ("ROM"),
    .width_a        (DATA_W),
    .widthad_a      (ADDR_W),
    .numwords_a     (2**ADDR_W),
    .outdata_reg_a  ("UNREGISTERED"),
    .address_aclr_a ("NONE"),
    .init_file      (INIT_FILE),
    .lpm_type       ("altsyncram")
  ) u_altsyncram (
    .clock0    (clock),
    .address_a (address),
    .rden_a    (rden),
    .q_a       (q)
  );
`else
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  // Output holds its last value when no read is requested, like the macro.
  always_comb begin
    q_d = q_q;
    if (rden) q_d = mem[address];
  end

  always_ff @(posedge clock) q_q <= q_d;

  assign q = q_q;
`endif

endmodule

// File: rtl/cmd_table_streamer.sv
// Streams one terminator-delimited string from the command-table ROM per request,
// with valid/ready backpressure, abort and length/overrun status.
module cmd_table_streamer
  import cmd_table_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 6,
  parameter                  INIT_FILE = "./cmd_parser_cmd_table.mif",
  parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(TERM_WORD_DEF),
  parameter int              MAX_LEN   = 16,
  localparam int             LEN_W     = len_width(MAX_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              abort,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done,
  output logic [LEN_W-1:0]  len,
  output logic              overrun
);

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [LEN_W-1:0]             fcnt_q, fcnt_d;
  logic [LEN_W-1:0]             ocnt_q, ocnt_d;
  logic                         inflight_q, inflight_d;
  logic [1:0][DATA_W-1:0]       buf_data_q, buf_data_d;
  logic [1:0]                   buf_last_q, buf_last_d;
  logic [1:0]                   occ_q, occ_d;
  logic                         done_q, done_d;
  logic [LEN_W-1:0]             len_q, len_d;
  logic                         overrun_q, overrun_d;

  logic [DATA_W-1:0]            rom_q;
  logic                         rd_issue;
  logic                         in_last;
  logic                         head_valid;
  logic [DATA_W-1:0]            head_data;
  logic                         head_last;
  logic                         pop;
  logic                         push;

  cmd_table_rom #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clock   (clock),
    .rden    (rd_issue),
    .address (addr_q),
    .q       (rom_q)
  );

  // fcnt_q equals the 1-based index of the word currently on the ROM output.
  assign in_last = (rom_q == TERM_WORD) || (fcnt_q == LEN_W'(MAX_LEN));

  // An empty buffer lets the returning ROM word through as the head directly.
  always_comb begin
    head_valid = (occ_q != 2'd0) || inflight_q;
    head_data  = '0;
    head_last  = 1'b0;
    if (occ_q != 2'd0) begin
      head_data = buf_data_q[0];
      head_last = buf_last_q[0];
    end else if (inflight_q) begin
      head_data = rom_q;
      head_last = in_last;
    end
  end

  assign pop  = head_valid && out_ready;
  assign push = inflight_q && !((occ_q == 2'd0) && out_ready);

  // Stop fetching the moment the final word shows up on the ROM output.
  assign rd_issue = (state_q == FETCH) && !abort &&
                    ((occ_q + {1'b0, inflight_q}) < 2'd2) &&
                    !(inflight_q && in_last);

  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    occ_d      = occ_q;
    if (pop && (occ_q != 2'd0)) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      occ_d         = occ_q - 2'd1;
    end
    if (push) begin
      buf_data_d[occ_d[0]] = rom_q;
      buf_last_d[occ_d[0]] = in_last;
      occ_d                = occ_d + 2'd1;
    end
    if (abort) occ_d = 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fcnt_d     = fcnt_q;
    ocnt_d     = ocnt_q;
    inflight_d = rd_issue;
    done_d     = 1'b0;
    len_d      = len_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = FETCH;
          addr_d  = req_addr;
          fcnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      FETCH: if (inflight_q && in_last) state_d = DRAIN;
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (rd_issue) begin
      addr_d = addr_q + ADDR_W'(1);
      fcnt_d = fcnt_q + LEN_W'(1);
    end
    if (pop) ocnt_d = ocnt_q + LEN_W'(1);

    // The last word may leave straight from the ROM output while still in FETCH.
    if (pop && head_last) begin
      state_d   = IDLE;
      done_d    = 1'b1;
      len_d     = ocnt_q + LEN_W'(1);
      overrun_d = (head_data != TERM_WORD);
    end

    if (abort) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
      done_d     = 1'b0;
      len_d      = len_q;
      overrun_d  = overrun_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      fcnt_q     <= '0;
      ocnt_q     <= '0;
      inflight_q <= 1'b0;
      buf_data_q <= '0;
      buf_last_q <= '0;
      occ_q      <= '0;
      done_q     <= 1'b0;
      len_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fcnt_q     <= fcnt_d;
      ocnt_q     <= ocnt_d;
      inflight_q <= inflight_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      occ_q      <= occ_d;
      done_q     <= done_d;
      len_q      <= len_d;
      overrun_q  <= overrun_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_last  = head_last;
  assign done      = done_q;
  assign len       = len_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_cmd_table_streamer.sv
// Randomized bench for cmd_table_streamer against a string-walking reference model.
module tb_cmd_table_streamer;

  localparam int DEPTH   = 64;
  localparam int MAX_LEN = 16;

  logic       clock = 1'b0;
  logic       reset, req_valid, abort, out_ready;
  logic [5:0] req_addr;
  logic       req_ready, out_valid, out_last, done, overrun;
  logic [7:0] out_data;
  logic [4:0] len;

  always #5 clock = ~clock;

  cmd_table_streamer #(
    .DATA_W(8), .ADDR_W(6), .TERM_WORD(8'h00), .MAX_LEN(MAX_LEN)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .abort(abort), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .done(done), .len(len), .overrun(overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom_img [DEPTH];
  logic [7:0] exp_q [$];
  int         exp_len;
  bit         exp_ovr;
  int         last_exp_len = 0;
  bit         last_exp_ovr = 0;

  logic [7:0] got_q [$];
  bit         got_last [$];
  int         done_cnt, first_lat, stall_err, last_k, done_k;
  bit         tmo, ovr_at, rr_at, done_after, rr_busy;
  logic [4:0] len_at;

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic poke(input int a, input logic [7:0] v);
    rom_img[a] = v;
    dut.u_rom.mem[a] = v;
  endtask

  // Reference: walk the table from addr, wrapping, until terminator or MAX_LEN words.
  function automatic void model(input int addr);
    exp_q.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      exp_q.push_back(rom_img[(addr + i) % DEPTH]);
      if (rom_img[(addr + i) % DEPTH] == 8'h00) break;
    end
    exp_len = exp_q.size();
    exp_ovr = (exp_q[exp_len-1] != 8'h00);
  endfunction

  function automatic int seq_errs();
    int e;
    e = 0;
    if (got_q.size() != exp_q.size()) return 100;
    foreach (exp_q[i]) begin
      if (got_q[i] !== exp_q[i]) e++;
      if (got_last[i] !== (i == exp_q.size() - 1)) e++;
    end
    return e;
  endfunction

  // mode 0: random out_ready at pct%; mode 1: fixed toggle pattern.
  // poke_k > 0: pulse a second request in that cycle while busy.
  task automatic run_stream(input int addr, input int mode, input int pct, input int poke_k);
    bit         rdy, stalled;
    logic [7:0] pd;
    logic       pl;
    got_q.delete(); got_last.delete();
    done_cnt = 0; first_lat = 0; stall_err = 0; last_k = 0; done_k = 0; tmo = 1;
    rr_busy = 1; stalled = 0; pd = '0; pl = 0;
    @(negedge clock);
    req_valid = 1; req_addr = addr[5:0]; out_ready = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      req_valid = (k == poke_k);
      if (k == poke_k) begin req_addr = 6'd62; rr_busy = req_ready; end
      if (stalled && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && first_lat == 0) first_lat = k;
      if (done) begin
        done_cnt++; done_k = k; len_at = len; ovr_at = overrun; rr_at = req_ready; tmo = 0;
        break;
      end
      rdy = (mode == 1) ? pat[(k-1) % 6] : ($urandom_range(99) < pct);
      out_ready = rdy;
      stalled = out_valid && !rdy; pd = out_data; pl = out_last;
      if (out_valid && rdy) begin
        got_q.push_back(out_data); got_last.push_back(out_last);
        if (out_last) last_k = k;
      end
    end
    @(negedge clock);
    done_after = done;
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; abort = 0; out_ready = 0; req_addr = '0;
    repeat (3) @(negedge clock);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_tests++; if ({out_valid, out_last, done, overrun} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_valid, out_last, done, overrun}); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_tests++; if (len !== 5'd0) begin n_fail++; $display("FAIL reset_len: got %0d want 0", len); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    poke(0, 8'h48); poke(1, 8'h4C); poke(2, 8'h50); poke(3, 8'h00);
    model(0);
    run_stream(0, 0, 100, 0);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    n_tests++; if (first_lat !== 2) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 2", first_lat); end
    n_tests++; if (seq_errs() !== 0) begin n_fail++; $display("FAIL basic_seq: got %0d words %0d errs want %0d words", got_q.size(), seq_errs(), exp_len); end
    n_tests++; if (last_k !== 5 || done_k !== 6) begin n_fail++; $display("FAIL basic_timing: got last %0d done %0d want 5 6", last_k, done_k); end
    n_tests++; if (len_at !== 5'(exp_len) || ovr_at !== exp_ovr) begin n_fail++; $display("FAIL basic_status: got len %0d ovr %b want %0d %b", len_at, ovr_at, exp_len, exp_ovr); end
    n_tests++; if (done_after !== 1'b0 || rr_at !== 1'b1) begin n_fail++; $display("FAIL basic_done_pulse: got after %b ready %b want 0 1", done_after, rr_at); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_backpressure();
    model(0);
    run_stream(0, 1, 0, 0);
    n_tests++; if (seq_errs() !== 0 || tmo) begin n_fail++; $display("FAIL bp_seq: got %0d words tmo %b want %0d", got_q.size(), tmo, exp_len); end
    n_tests++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
    n_tests++; if (done_cnt !== 1 || done_k - last_k !== 1) begin n_fail++; $display("FAIL bp_done: got count %0d gap %0d want 1 1", done_cnt, done_k - last_k); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_wrap();
    poke(62, 8'h41); poke(63, 8'h42); poke(0, 8'h00);
    model(62);
    run_stream(62, 0, 70, 0);
    n_tests++; if (seq_errs() !== 0 || tmo) begin n_fail++; $display("FAIL wrap_seq: got %0d words want %0d", got_q.size(), exp_len); end
    n_tests++; if (len_at !== 5'd3 || ovr_at !== 1'b0) begin n_fail++; $display("FAIL wrap_status: got len %0d ovr %b want 3 0", len_at, ovr_at); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_overrun();
    for (int i = 8; i <= 24; i++) poke(i, 8'(8'h60 + i));
    model(8);
    run_stream(8, 0, 60, 3);
    n_tests++; if (seq_errs() !== 0 || tmo) begin n_fail++; $display("FAIL ovr_seq: got %0d words want %0d", got_q.size(), exp_len); end
    n_tests++; if (len_at !== 5'd16 || ovr_at !== 1'b1) begin n_fail++; $display("FAIL ovr_status: got len %0d ovr %b want 16 1", len_at, ovr_at); end
    n_tests++; if (rr_busy !== 1'b0) begin n_fail++; $display("FAIL busy_req_ready: got %b want 0", rr_busy); end
    for (int i = 40; i <= 54; i++) poke(i, 8'(8'h20 + i));
    poke(55, 8'h00);
    model(40);
    run_stream(40, 0, 100, 0);
    n_tests++; if (len_at !== 5'd16 || ovr_at !== 1'b0 || seq_errs() !== 0) begin n_fail++; $display("FAIL term_at_max: got len %0d ovr %b errs %0d want 16 0 0", len_at, ovr_at, seq_errs()); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_empty();
    poke(5, 8'h00);
    model(5);
    run_stream(5, 0, 50, 0);
    n_tests++; if (seq_errs() !== 0 || tmo) begin n_fail++; $display("FAIL empty_seq: got %0d words want 1", got_q.size()); end
    n_tests++; if (len_at !== 5'd1 || ovr_at !== 1'b0) begin n_fail++; $display("FAIL empty_status: got len %0d ovr %b want 1 0", len_at, ovr_at); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_abort();
    int acc, dcnt;
    bit seen;
    for (int i = 16; i < 36; i++) poke(i, 8'(8'h61 + i));
    @(negedge clock);
    req_valid = 1; req_addr = 6'd16; out_ready = 1;
    acc = 0;
    for (int k = 0; k < 50 && acc < 2; k++) begin
      @(negedge clock);
      req_valid = 0;
      if (out_valid) acc++;
    end
    @(negedge clock);
    abort = 1;
    @(negedge clock);
    abort = 0;
    n_tests++; if (acc !== 2) begin n_fail++; $display("FAIL abort_setup: got %0d words want 2", acc); end
    n_tests++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got valid %b ready %b want 0 1", out_valid, req_ready); end
    n_tests++; if (len !== 5'(last_exp_len) || overrun !== last_exp_ovr) begin n_fail++; $display("FAIL abort_len_held: got %0d %b want %0d %b", len, overrun, last_exp_len, last_exp_ovr); end
    dcnt = done;
    repeat (4) begin @(negedge clock); dcnt += done; end
    n_tests++; if (dcnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
    // Abort in the same cycle the last word is accepted.
    req_valid = 1; req_addr = 6'd5; out_ready = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      req_valid = 0;
      seen = out_valid;
    end
    out_ready = 1; abort = 1;
    @(negedge clock);
    abort = 0; out_ready = 0;
    n_tests++; if (!seen || done !== 1'b0 || len !== 5'(last_exp_len) || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_vs_last: got seen %b done %b len %0d valid %b want 1 0 %0d 0", seen, done, len, out_valid, last_exp_len); end
    model(16);
    run_stream(16, 0, 80, 0);
    n_tests++; if (seq_errs() !== 0 || tmo || len_at !== 5'(exp_len) || ovr_at !== exp_ovr) begin n_fail++; $display("FAIL abort_restart: got %0d words len %0d ovr %b want %0d %0d %b", got_q.size(), len_at, ovr_at, exp_len, exp_len, exp_ovr); end
    last_exp_len = exp_len; last_exp_ovr = exp_ovr;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    req_valid = 1; req_addr = 6'd16; out_ready = 1;
    repeat (4) begin @(negedge clock); req_valid = 0; end
    reset = 1;
    @(negedge clock);
    reset = 0; out_ready = 0;
    n_tests++; if ({req_ready, out_valid, out_last, done, overrun} !== 5'b10000 || out_data !== 8'h00 || len !== 5'd0) begin n_fail++; $display("FAIL reset_mid: got rr %b v %b l %b d %b o %b data %h len %0d want reset values", req_ready, out_valid, out_last, done, overrun, out_data, len); end
    last_exp_len = 0; last_exp_ovr = 0;
  endtask

  task automatic test_random();
    int a, pct;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++)
        poke(i, ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      a = $urandom_range(DEPTH - 1);
      pct = $urandom_range(20, 100);
      model(a);
      run_stream(a, 0, pct, 0);
      n_tests++;
      if (seq_errs() !== 0 || tmo || stall_err !== 0 || done_cnt !== 1 ||
          len_at !== 5'(exp_len) || ovr_at !== exp_ovr || done_after !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: addr %0d got %0d words len %0d ovr %b stall %0d tmo %b want %0d words ovr %b",
                 it, a, got_q.size(), len_at, ovr_at, stall_err, tmo, exp_len, exp_ovr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) poke(i, 8'($urandom_range(1, 255)));
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_overrun();
    test_empty();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
